input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end conditioner that turns the two raw, asynchronous push-button/switch inputs into the clean `a` and `b` levels consumed by `behavioral_model`. Each channel is synchronised into the `clk` domain and debounced with a per-channel state machine. Each channel then presents a registered clean level plus single-cycle rise and fall pulses. It sits directly upstream of `behavioral_model` in the board-level top.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flop count. Legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised cycles required before the clean level changes. Legal values are 1 or more.

Ports:
- `clk`, input, 1: single system clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `a_raw`, input, 1: asynchronous raw input for channel A.
- `b_raw`, input, 1: asynchronous raw input for channel B.
- `a`, output, 1: debounced level for channel A. Connects to `behavioral_model.a`.
- `b`, output, 1: debounced level for channel B. Connects to `behavioral_model.b`.
- `a_rise`, `b_rise`, output, 1: one-cycle pulse when the clean level goes 0→1.
- `a_fall`, `b_fall`, output, 1: one-cycle pulse when the clean level goes 1→0.

## Operation
- The two channels are identical and fully independent. There is no cross-channel interaction.
- **Synchroniser:** a shift chain of `SYNC_STAGES` flops. `sync` is the last stage.
- **Debounce FSM states:** `LOW`, `RISE_PEND`, `HIGH`, `FALL_PEND`. The clean output is 1 in `HIGH` and `FALL_PEND`.
- **Transitions from `LOW`:**
  - `sync`=1 goes to `RISE_PEND` with cnt=1.
  - When `DEBOUNCE_CYCLES`=1, it goes directly to `HIGH` instead.
- **Transitions from `RISE_PEND`:**
  - `sync`=0 returns to `LOW` with cnt=0. This is the glitch reject.
  - `sync`=1 with cnt==`DEBOUNCE_CYCLES`-1 goes to `HIGH`, sets cnt=0 and asserts rise.
  - Otherwise cnt increments.
- **`HIGH` and `FALL_PEND`:** mirror the `LOW`/`RISE_PEND` behaviour with polarity inverted. Falling into `LOW` asserts fall.
- **Counter:** width is `$clog2(DEBOUNCE_CYCLES+1)`. It never exceeds `DEBOUNCE_CYCLES`-1 and never wraps.
- **Pulses:** rise and fall are registered and high for exactly one cycle. They are mutually exclusive per channel. The minimum spacing between consecutive pulses on one channel is `DEBOUNCE_CYCLES` cycles.

## Timing
- **Reset values:** all outputs are 0. All synchroniser flops are 0. Each FSM is in `LOW` with cnt=0.
- **Reset priority:** reset has priority over everything and takes effect at the first rising edge where it is sampled high.
- **Reset mid-operation:** a pending debounce is aborted. If the raw input is still 1 after reset releases, the full latency is re-run and a rise pulse is produced.
- **Latency:** the raw input is stable before edge k. The clean level and the pulse update on edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1, which is k+5 with the defaults.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change and no pulse.
- **Metastability:** the outputs depend only on the final synchroniser stage, never on `a_raw`/`b_raw` directly.
- **Simultaneous events:** simultaneous transitions on A and B are handled independently in the same cycles.

## Structure
- Package `input_conditioner_pkg` holds:
  - the enum `db_state_t` (`LOW`, `RISE_PEND`, `HIGH`, `FALL_PEND`);
  - the default constants for `SYNC_STAGES` and `DEBOUNCE_CYCLES`.
- Sub-module `debounce_channel`:
  - contains one synchroniser, the FSM and the counter;
  - has ports `clk`, `reset`, `raw`, `level`, `rise`, `fall`;
  - is instantiated twice in `input_conditioner`.

## Test plan
All scenarios use the default parameters.
1. **Reset:** hold `reset`=1 for 2 cycles with `a_raw`=`b_raw`=1. Required response: all outputs are 0 throughout reset. After release, `a` and `b` go to 1 on the 6th edge, each with a one-cycle rise pulse.
2. **Clean rise and fall:** `a_raw` goes 0→1 before edge k. Required response: `a`=1 and `a_rise`=1 after edge k+5, and `a_rise`=0 after edge k+6. Then `a_raw` goes 1→0 before edge j. Required response: `a`=0 and `a_fall`=1 after edge j+5.
3. **Glitch:** `a_raw` is high for 3 cycles, then low. Required response: `a` stays 0, and `a_rise`/`a_fall` never assert.
4. **Bounce:** `a_raw` toggles 1,0,1,0,1 on successive cycles, then is held at 1. Required response: exactly one `a_rise`, 5 edges after the final 0→1.
5. **Independence:** `a_raw`↑ and `b_raw`↑ in the same cycle, then `b_raw` glitches for 2 cycles while `a` is `HIGH`. Required response: `a_rise` and `b_rise` fire together, `b` is unaffected by the glitch, and `a` holds 1.
6. **Reset mid-debounce:** `a_raw`↑ at edge k, then `reset` for 1 cycle at edge k+3. Required response: no pulse at k+5. `a`=1 and `a_rise` appear 6 edges after reset releases.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the two-channel input conditioner.
// Holds the debounce state encoding and the default parameter values.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        LOW,
        RISE_PEND,
        HIGH,
        FALL_PEND
    } db_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/debounce_channel.sv
// One conditioner channel: synchroniser chain, debounce FSM and counter.
// Produces a registered clean level plus one-cycle rise/fall pulses.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Next-state, counter and pulse decode for the debounce FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW: begin
                if (sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = RISE_PEND;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RISE_PEND: begin
                if (!sync) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = LOW;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = FALL_PEND;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            FALL_PEND: begin
                if (sync) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == HIGH) || (state_d == FALL_PEND);
    end

    // Register FSM state, counter, clean level and edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Two independent debounced channels feeding behavioral_model a/b.
// Each raw input gets its own synchroniser and debounce FSM.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise,
    output logic a_fall,
    output logic b_fall
);

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch_a (
        .clk  (clk),
        .reset(reset),
        .raw  (a_raw),
        .level(a),
        .rise (a_rise),
        .fall (a_fall)
    );

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch_b (
        .clk  (clk),
        .reset(reset),
        .raw  (b_raw),
        .level(b),
        .rise (b_rise),
        .fall (b_fall)
    );

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner at default parameters.
// Vector table plus hand-written multi-cycle corner sequences.
module tb_input_conditioner;

    logic clk;
    logic reset;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic a_rise;
    logic b_rise;
    logic a_fall;
    logic b_fall;

    int nvec;
    int nbad;

    typedef struct {
        logic       rst;
        logic       ar;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    input_conditioner dut (
        .clk   (clk),
        .reset (reset),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a),
        .b     (b),
        .a_rise(a_rise),
        .b_rise(b_rise),
        .a_fall(a_fall),
        .b_fall(b_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n copies of one vector; exp = {a,a_rise,a_fall,b,b_rise,b_fall}
    function automatic void add(input int n, input logic rst,
                                input logic ar, input logic br,
                                input logic [5:0] exp);
        vec_t v;
        v.rst = rst;
        v.ar  = ar;
        v.br  = br;
        v.exp = exp;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic step(input string nm, input int idx,
                        input logic r, input logic ar, input logic br,
                        input logic [5:0] exp);
        logic [5:0] got;
        reset = r;
        a_raw = ar;
        b_raw = br;
        @(posedge clk);
        #1;
        got = {a, a_rise, a_fall, b, b_rise, b_fall};
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s step %0d: got %b want %b (a,ar,af,b,br,bf)",
                     nm, idx, got, exp);
        end
    endtask

    initial begin
        nvec  = 0;
        nbad  = 0;
        reset = 1'b1;
        a_raw = 1'b1;
        b_raw = 1'b1;

        // reset with both raw high, then rise on 6th edge after release
        add(2, 1, 1, 1, 6'b000000);
        add(5, 0, 1, 1, 6'b000000);
        add(1, 0, 1, 1, 6'b110110);
        add(1, 0, 1, 1, 6'b100100);
        // clean fall on A, B held high
        add(5, 0, 0, 1, 6'b100100);
        add(1, 0, 0, 1, 6'b001100);
        add(1, 0, 0, 1, 6'b000100);
        // clean rise on A
        add(5, 0, 1, 1, 6'b000100);
        add(1, 0, 1, 1, 6'b110100);
        add(1, 0, 1, 1, 6'b100100);
        // simultaneous fall on both
        add(5, 0, 0, 0, 6'b100100);
        add(1, 0, 0, 0, 6'b001001);
        add(1, 0, 0, 0, 6'b000000);
        // simultaneous rise on both
        add(5, 0, 1, 1, 6'b000000);
        add(1, 0, 1, 1, 6'b110110);
        add(1, 0, 1, 1, 6'b100100);
        // two-cycle low glitch on B while both HIGH
        add(2, 0, 1, 0, 6'b100100);
        add(6, 0, 1, 1, 6'b100100);
        // return both low
        add(5, 0, 0, 0, 6'b100100);
        add(1, 0, 0, 0, 6'b001001);
        add(4, 0, 0, 0, 6'b000000);

        foreach (tbl[i])
            step("table", i, tbl[i].rst, tbl[i].ar, tbl[i].br, tbl[i].exp);

        // 3-cycle high glitch on A: no change, no pulse
        for (int i = 0; i < 10; i++)
            step("glitch", i, 1'b0, logic'(i < 3), 1'b0, 6'b000000);

        // exactly 4-cycle pulse on A: rise then fall 4 edges later
        for (int i = 0; i < 12; i++)
            step("min_pulse", i, 1'b0, logic'(i < 4), 1'b0,
                 (i == 5)           ? 6'b110000 :
                 (i >= 6 && i <= 8) ? 6'b100000 :
                 (i == 9)           ? 6'b001000 : 6'b000000);

        // bounce 1,0,1,0,1 then hold: single rise 5 edges after last 0->1
        for (int i = 0; i < 12; i++)
            step("bounce", i, 1'b0, logic'((i % 2 == 0) || (i > 4)), 1'b0,
                 (i == 9) ? 6'b110000 :
                 (i > 9)  ? 6'b100000 : 6'b000000);
        for (int i = 0; i < 7; i++)
            step("bounce_rel", i, 1'b0, 1'b0, 1'b0,
                 (i < 5)  ? 6'b100000 :
                 (i == 5) ? 6'b001000 : 6'b000000);

        // reset mid-debounce at k+3: full latency re-run after release
        for (int i = 0; i < 13; i++)
            step("rst_mid", i, logic'(i == 3), 1'b1, 1'b0,
                 (i == 9) ? 6'b110000 :
                 (i > 9)  ? 6'b100000 : 6'b000000);

        // reset while A is HIGH clears outputs at once
        step("rst_high", 0, 1'b1, 1'b1, 1'b1, 6'b000000);
        step("rst_high", 1, 1'b0, 1'b1, 1'b1, 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
